scrambler_58b: RTL and testbench

Parametrised self-synchronising 10GBASE-R scrambler/descrambler, polynomial 1 + x^39 + x^58, usable at 32- or 64-bit datapath width in either direction. It sits between the 64b/66b encoder and the TX gearbox in scramble mode, and between the RX gearbox/block-lock and the decoder in descramble mode. The 2-bit sync header and the even/odd word flag pass alongside the payload with matched latency. It adds seed loading and a descrambler lock indication.

---
 rtl/scrambler_pkg.sv | 19 +
 rtl/scr_unroll.sv | 34 +++
 rtl/scrambler_58b.sv | 126 ++++++++++++
 tb/tb_scrambler_58b.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scrambler_pkg.sv
// Shared constants and types for the 1 + x^39 + x^58 self-synchronising scrambler.
// Optional feature macro used by the top: SCRAMBLER_BYPASS_EN.
package scrambler_pkg;

    localparam int STATE_W = 58;
    localparam int TAP_A   = 38;
    localparam int TAP_B   = 57;

    typedef logic [STATE_W-1:0] scr_state_t;

    localparam logic SCR_MODE_TX = 1'b0;
    localparam logic SCR_MODE_RX = 1'b1;

    // Words needed before every state bit has been refilled from the line.
    function automatic int warm_words(input int data_w);
        return (STATE_W + data_w - 1) / data_w;
    endfunction

endpackage

// File: rtl/scr_unroll.sv
// Combinational DATA_W-step unroll of the scrambler recurrence; bit 0 is processed first.
// Scramble feeds the output bit back into the state, descramble feeds the line bit.
module scr_unroll
    import scrambler_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  scr_state_t        state_i,
    input  logic [DATA_W-1:0] din,
    input  logic              mode,
    output logic [DATA_W-1:0] dout,
    output scr_state_t        state_next
);

    always_comb begin
        scr_state_t        s;
        logic [DATA_W-1:0] o;
        logic              t;
        logic              fb;
        s = state_i;
        o = '0;
        t = 1'b0;
        fb = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            t    = s[TAP_A] ^ s[TAP_B];
            o[i] = din[i] ^ t;
            fb   = (mode == SCR_MODE_RX) ? din[i] : o[i];
            s    = {s[STATE_W-2:0], fb};
        end
        dout       = o;
        state_next = s;
    end

endmodule

// File: rtl/scrambler_58b.sv
// 10GBASE-R scrambler/descrambler top: registers, lock counter, seed load and optional bypass.
// Define SCRAMBLER_BYPASS_EN to add the `bypass` input port.
module scrambler_58b
    import scrambler_pkg::*;
#(
    parameter int         DATA_W = 32,
    parameter int         MODE   = 0,
    parameter scr_state_t SEED   = 58'h3FF_FFFF_FFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic [1:0]        ctrlin,
    input  logic              din_en,
    input  logic              evenin,
`ifdef SCRAMBLER_BYPASS_EN
    input  logic              bypass,
`endif
    input  logic              seed_load,
    input  scr_state_t        seed,
    output logic [DATA_W-1:0] dout,
    output logic [1:0]        ctrlout,
    output logic              dout_en,
    output logic              evenout,
    output logic              locked
);

    generate
        if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
            $error("scrambler_58b: DATA_W must be 32 or 64");
        end
    endgenerate

    localparam logic       MODE_BIT = (MODE != 0);
    localparam int         WARM     = warm_words(DATA_W);
    localparam logic [1:0] WARM_C   = 2'(WARM);

    scr_state_t        state_q, state_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [1:0]        ctrlout_q, ctrlout_d;
    logic              dout_en_q, dout_en_d;
    logic              evenout_q, evenout_d;
    logic              locked_q, locked_d;
    logic [1:0]        cnt_q, cnt_d;

    logic              bypass_act;
    logic [DATA_W-1:0] unroll_dout;
    scr_state_t        unroll_next;

`ifdef SCRAMBLER_BYPASS_EN
    assign bypass_act = bypass;
`else
    assign bypass_act = 1'b0;
`endif

    scr_unroll #(
        .DATA_W (DATA_W)
    ) u_unroll (
        .state_i    (state_q),
        .din        (din),
        .mode       (MODE_BIT),
        .dout       (unroll_dout),
        .state_next (unroll_next)
    );

    always_comb begin
        state_d   = state_q;
        dout_d    = dout_q;
        ctrlout_d = ctrlout_q;
        cnt_d     = cnt_q;
        dout_en_d = din_en;
        evenout_d = evenin;

        if (din_en) begin
            ctrlout_d = ctrlin;
            if (bypass_act) begin
                dout_d = din;
            end else begin
                dout_d  = unroll_dout;
                state_d = unroll_next;
                if (cnt_q != WARM_C) begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
        end

        // The word on this cycle already used the old state; only the next one sees the seed.
        if (seed_load) begin
            state_d = seed;
            cnt_d   = '0;
        end

        if (MODE_BIT == SCR_MODE_RX) begin
            locked_d = (cnt_d == WARM_C);
        end else begin
            locked_d = !seed_load;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= SEED;
            dout_q    <= '0;
            ctrlout_q <= '0;
            dout_en_q <= 1'b0;
            evenout_q <= 1'b0;
            locked_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            dout_q    <= dout_d;
            ctrlout_q <= ctrlout_d;
            dout_en_q <= dout_en_d;
            evenout_q <= evenout_d;
            locked_q  <= locked_d;
            cnt_q     <= cnt_d;
        end
    end

    assign dout    = dout_q;
    assign ctrlout = ctrlout_q;
    assign dout_en = dout_en_q;
    assign evenout = evenout_q;
    assign locked  = locked_q;

endmodule

// File: tb/tb_scrambler_58b.sv
// Directed bench for scrambler_58b: 32-bit TX/RX pair on shared inputs plus a 64-bit TX->RX loopback.
module tb_scrambler_58b;

    localparam logic [57:0] SEED_ONES = 58'h3FF_FFFF_FFFF_FFFF;

    logic clk;
    logic rst_n;

    logic [31:0] din_a;
    logic [1:0]  ctrl_a;
    logic        en_a, even_a, seed_load_a, byp_a;
    logic [57:0] seed_a;

    logic [31:0] tx32_dout, rx32_dout;
    logic [1:0]  tx32_ctrl, rx32_ctrl;
    logic        tx32_en, rx32_en, tx32_even, rx32_even, tx32_locked, rx32_locked;

    logic [63:0] din_b;
    logic [1:0]  ctrl_b;
    logic        en_b, even_b;

    logic [63:0] tx64_dout, rx64_dout;
    logic [1:0]  tx64_ctrl, rx64_ctrl;
    logic        tx64_en, rx64_en, tx64_even, rx64_even, tx64_locked, rx64_locked;

    logic [57:0] mt, mr;
    int          rcnt;
    logic [31:0] exp_tx, exp_rx;
    logic [1:0]  exp_ctrl;

    logic [66:0] exp_q[$];

    int checks;
    int errors;

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    scrambler_58b #(.DATA_W(32), .MODE(0)) u_tx32 (
        .clk(clk), .rst_n(rst_n), .din(din_a), .ctrlin(ctrl_a), .din_en(en_a), .evenin(even_a),
`ifdef SCRAMBLER_BYPASS_EN
        .bypass(byp_a),
`endif
        .seed_load(seed_load_a), .seed(seed_a), .dout(tx32_dout), .ctrlout(tx32_ctrl),
        .dout_en(tx32_en), .evenout(tx32_even), .locked(tx32_locked)
    );

    scrambler_58b #(.DATA_W(32), .MODE(1)) u_rx32 (
        .clk(clk), .rst_n(rst_n), .din(din_a), .ctrlin(ctrl_a), .din_en(en_a), .evenin(even_a),
`ifdef SCRAMBLER_BYPASS_EN
        .bypass(byp_a),
`endif
        .seed_load(seed_load_a), .seed(seed_a), .dout(rx32_dout), .ctrlout(rx32_ctrl),
        .dout_en(rx32_en), .evenout(rx32_even), .locked(rx32_locked)
    );

    scrambler_58b #(.DATA_W(64), .MODE(0)) u_tx64 (
        .clk(clk), .rst_n(rst_n), .din(din_b), .ctrlin(ctrl_b), .din_en(en_b), .evenin(even_b),
`ifdef SCRAMBLER_BYPASS_EN
        .bypass(1'b0),
`endif
        .seed_load(1'b0), .seed(58'h0), .dout(tx64_dout), .ctrlout(tx64_ctrl),
        .dout_en(tx64_en), .evenout(tx64_even), .locked(tx64_locked)
    );

    scrambler_58b #(.DATA_W(64), .MODE(1), .SEED(58'h0)) u_rx64 (
        .clk(clk), .rst_n(rst_n), .din(tx64_dout), .ctrlin(tx64_ctrl), .din_en(tx64_en),
        .evenin(tx64_even),
`ifdef SCRAMBLER_BYPASS_EN
        .bypass(1'b0),
`endif
        .seed_load(1'b0), .seed(58'h0), .dout(rx64_dout), .ctrlout(rx64_ctrl),
        .dout_en(rx64_en), .evenout(rx64_even), .locked(rx64_locked)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bit-serial reference of the recurrence.
    function automatic void ref_word(input logic [57:0] s_in, input logic [63:0] d, input int w,
                                     input logic rx, output logic [63:0] o,
                                     output logic [57:0] s_out);
        logic [57:0] s;
        logic        t;
        s = s_in;
        o = '0;
        for (int i = 0; i < w; i++) begin
            t    = s[38] ^ s[57];
            o[i] = d[i] ^ t;
            s    = {s[56:0], (rx ? d[i] : o[i])};
        end
        s_out = s;
    endfunction

    // driver tasks
    task automatic do_reset(input logic [31:0] data, input logic en);
        rst_n = 1'b0;
        din_a = data;
        en_a = en;
        ctrl_a = 2'b11;
        even_a = 1'b1;
        seed_load_a = 1'b0;
        en_b = 1'b0;
        din_b = '1;
        ctrl_b = 2'b11;
        even_b = 1'b1;
        @(posedge clk);
        #1;
        mt = SEED_ONES;
        mr = SEED_ONES;
        rcnt = 0;
        exp_tx = '0;
        exp_rx = '0;
        exp_ctrl = '0;
        check("rst_tx32_dout", tx32_dout, 0);
        check("rst_tx32_ctrl", tx32_ctrl, 0);
        check("rst_tx32_en", tx32_en, 0);
        check("rst_tx32_even", tx32_even, 0);
        check("rst_tx32_locked", tx32_locked, 0);
        check("rst_rx32_dout", rx32_dout, 0);
        check("rst_rx32_locked", rx32_locked, 0);
        check("rst_tx64_dout", tx64_dout, 0);
        check("rst_rx64_locked", rx64_locked, 0);
        check("rst_rx64_en", rx64_en, 0);
        rst_n = 1'b1;
        en_a = 1'b0;
    endtask

    task automatic drive_a(input logic en, input logic [31:0] data, input logic [1:0] ctrl,
                           input logic even, input logic sl, input logic [57:0] sd);
        logic [63:0] o;
        logic [57:0] ns;
        en_a = en;
        din_a = data;
        ctrl_a = ctrl;
        even_a = even;
        seed_load_a = sl;
        seed_a = sd;
        if (en) begin
            exp_ctrl = ctrl;
            if (byp_a) begin
                exp_tx = data;
                exp_rx = data;
            end else begin
                ref_word(mt, {32'h0, data}, 32, 1'b0, o, ns);
                exp_tx = o[31:0];
                mt = ns;
                ref_word(mr, {32'h0, data}, 32, 1'b1, o, ns);
                exp_rx = o[31:0];
                mr = ns;
                if (rcnt < 2) rcnt++;
            end
        end
        if (sl) begin
            mt = sd;
            mr = sd;
            rcnt = 0;
        end
        @(posedge clk);
        #1;
        check("tx32_dout", tx32_dout, exp_tx);
        check("tx32_ctrl", tx32_ctrl, exp_ctrl);
        check("tx32_en", tx32_en, en);
        check("tx32_even", tx32_even, even);
        check("tx32_locked", tx32_locked, !sl);
        check("rx32_dout", rx32_dout, exp_rx);
        check("rx32_ctrl", rx32_ctrl, exp_ctrl);
        check("rx32_en", rx32_en, en);
        check("rx32_locked", rx32_locked, (rcnt == 2));
        en_a = 1'b0;
        seed_load_a = 1'b0;
    endtask

    initial begin
        logic [66:0] e;
        logic [63:0] d;
        int          rx_idx;
        checks = 0;
        errors = 0;
        byp_a = 1'b0;
        seed_a = '0;
        do_reset(32'h0, 1'b0);
        do_reset(32'h0, 1'b0);

        // Scramble zeros from the all-ones seed.
        drive_a(1'b1, 32'h0, 2'b01, 1'b0, 1'b0, 58'h0);
        check("t1_w0_const", tx32_dout, 32'h0000_0000);
        check("t1_rx_lock_w0", rx32_locked, 0);
        drive_a(1'b1, 32'h0, 2'b10, 1'b1, 1'b0, 58'h0);
        check("t1_w1_const", tx32_dout, 32'h03FF_FF80);
        check("t1_rx_w1_const", rx32_dout, 32'h03FF_FF80);
        check("t1_rx_lock_w1", rx32_locked, 1);
        drive_a(1'b1, 32'h0, 2'b01, 1'b0, 1'b0, 58'h0);

        // Gaps at ~30% duty.
        for (int c = 0; c < 200; c++) begin
            drive_a(($urandom_range(0, 99) < 30), $urandom, 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'b0, 58'h0);
        end

        // Seed load together with a valid word.
        drive_a(1'b1, $urandom, 2'b01, 1'b0, 1'b1, 58'h1);
        check("t4_rx_lock_drop", rx32_locked, 0);
        check("t4_tx_lock_drop", tx32_locked, 0);
        drive_a(1'b1, 32'hFFFF_FFFF, 2'b10, 1'b1, 1'b0, 58'h0);
        check("t4_tx_seeded_const", tx32_dout, 32'hFFFF_FFFF);
        check("t4_rx_seeded_const", rx32_dout, 32'hFFFF_FFFF);
        check("t4_rx_lock_1word", rx32_locked, 0);
        check("t4_tx_lock_back", tx32_locked, 1);
        drive_a(1'b1, $urandom, 2'b01, 1'b0, 1'b0, 58'h0);
        check("t4_rx_lock_2words", rx32_locked, 1);

        // Reset mid-stream with a word in flight.
        for (int c = 0; c < 10; c++) begin
            drive_a(1'b1, $urandom, 2'b01, 1'($urandom_range(0, 1)), 1'b0, 58'h0);
        end
        do_reset(32'h1234_5678, 1'b1);
        drive_a(1'b1, 32'h0, 2'b01, 1'b0, 1'b0, 58'h0);
        check("t5_replay_w0", tx32_dout, 32'h0000_0000);
        drive_a(1'b1, 32'h0, 2'b10, 1'b1, 1'b0, 58'h0);
        check("t5_replay_w1", tx32_dout, 32'h03FF_FF80);

`ifdef SCRAMBLER_BYPASS_EN
        byp_a = 1'b1;
        for (int c = 0; c < 5; c++) begin
            drive_a(1'b1, 32'hDEAD_BEEF, 2'b01, 1'b0, 1'b0, 58'h0);
            check("t6_bypass_const", tx32_dout, 32'hDEAD_BEEF);
        end
        byp_a = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive_a(1'b1, $urandom, 2'b10, 1'b1, 1'b0, 58'h0);
        end
`endif

        // 64-bit loopback, descrambler seeded with zero.
        do_reset(32'h0, 1'b0);
        rx_idx = 0;
        for (int c = 0; c < 1003; c++) begin
            if (c < 1000) begin
                d = {$urandom, $urandom};
                din_b = d;
                ctrl_b = 2'($urandom_range(1, 2));
                even_b = c[0];
                en_b = 1'b1;
                exp_q.push_back({even_b, ctrl_b, d});
            end else begin
                en_b = 1'b0;
            end
            @(posedge clk);
            #1;
            if (rx64_en) begin
                if (exp_q.size() == 0) begin
                    check("lb_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (rx_idx > 0) check("lb_data", rx64_dout, e[63:0]);
                    check("lb_ctrl", rx64_ctrl, e[65:64]);
                    check("lb_even", rx64_even, e[66]);
                    if (rx_idx == 0) check("lb_lock_first", rx64_locked, 1);
                    rx_idx++;
                end
            end else if (rx_idx == 0) begin
                check("lb_lock_before", rx64_locked, 0);
            end
        end
        check("lb_drain", exp_q.size(), 0);
        check("lb_count", rx_idx, 1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
